// File: rtl/mc_mdu.sv
// mc_mdu: multi-cycle multiply/divide unit with HI/LO result registers.
// One radix-2 step per cycle: shift-add multiply or restoring divide, both
// on operand magnitudes, followed by a single sign-fixup cycle.
module mc_mdu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_e;

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;       // raw dividend, returned as-is on divide by zero
    logic [WIDTH-1:0] opb_q, opb_d;   // |b|: multiplicand or divisor
    logic [WIDTH-1:0] acc_q, acc_d;   // product high half / partial remainder
    logic [WIDTH-1:0] sh_q, sh_d;     // multiplier bits out / quotient bits in
    logic             div_q, div_d;
    logic             sa_q, sa_d;
    logic             sb_q, sb_d;
    logic             bzero_q, bzero_d;

    logic             accept;
    logic             signed_op;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   sum, shifted, trial;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] quo, rem;

    // Next-state, datapath step and result fixup
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        sh_d    = sh_q;
        div_d   = div_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        bzero_d = bzero_q;

        accept    = start && !flush && (state_q == S_IDLE || state_q == S_DONE);
        signed_op = !op[0];
        abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
        abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;

        sum     = sh_q[0] ? ({1'b0, acc_q} + {1'b0, opb_q}) : {1'b0, acc_q};
        shifted = {acc_q, sh_q[WIDTH-1]};
        trial   = shifted - {1'b0, opb_q};

        prod = {acc_q, sh_q};
        if (sa_q ^ sb_q) prod = -prod;
        quo = (sa_q ^ sb_q) ? -sh_q : sh_q;
        rem = sa_q ? -acc_q : acc_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (!op[2]) begin
                        a_d     = a;
                        opb_d   = abs_b;
                        acc_d   = '0;
                        sh_d    = abs_a;
                        div_d   = op[1];
                        sa_d    = signed_op && a[WIDTH-1];
                        sb_d    = signed_op && b[WIDTH-1];
                        bzero_d = (b == '0);
                        cnt_d   = '0;
                        state_d = S_RUN;
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            S_RUN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (div_q) begin
                        if (!trial[WIDTH]) begin
                            acc_d = trial[WIDTH-1:0];
                            sh_d  = {sh_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = shifted[WIDTH-1:0];
                            sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = sum[WIDTH:1];
                        sh_d  = {sum[0], sh_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_STEP) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    if (!div_q) begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end else if (bzero_q) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            sh_q    <= '0;
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bzero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            div_q   <= div_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            bzero_q <= bzero_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mc_mdu.sv
// Scoreboard bench for mc_mdu (WIDTH=32): directed vectors push expected
// hi/lo and done cycle; a negedge monitor pops and compares on each done.
module tb_mc_mdu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned cyc;
    } exp_t;
    exp_t exp_q[$];

    mc_mdu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst && done) begin
            if (exp_q.size() == 0) begin
                check("spurious_done", 64'(done), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("result_hi", 64'(hi), 64'(e.hi));
                check("result_lo", 64'(lo), 64'(e.lo));
                check("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // Called at a negedge; start is sampled at the following posedge
    task automatic issue(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                         input bit push, input logic [31:0] eh, input logic [31:0] el);
        exp_t e;
        op = o; a = aa; b = bb; start = 1'b1;
        if (push) begin
            e.hi = eh; e.lo = el; e.cyc = cyc + 34;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic drain();
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("drain_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        #1 rst = 1'b0;
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // First start right after reset release
        issue(3'b000, 32'hFFFF_FFFD, 32'd5, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        drain();
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, 32'h0000_0001);
        drain();
        issue(3'b010, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        drain();
        issue(3'b011, 32'd7, 32'd0, 1, 32'd7, 32'hFFFF_FFFF);
        drain();
        issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, 32'h8000_0000);
        drain();
        issue(3'b010, 32'd7, 32'hFFFF_FFFE, 1, 32'd1, 32'hFFFF_FFFD);
        drain();
        issue(3'b010, 32'hFFFF_FFF9, 32'd0, 1, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
        drain();

        // MTLO, then a reserved op that must change nothing
        issue(3'b101, 32'hCAFE_F00D, 32'd0, 0, '0, '0);
        check("mtlo_lo", 64'(lo), 64'hCAFE_F00D);
        check("mtlo_hi", 64'(hi), 64'hFFFF_FFF9);
        issue(3'b110, 32'h1111_1111, 32'h2222_2222, 0, '0, '0);
        check("reserved_busy", 64'(busy), 64'd0);
        check("reserved_hi", 64'(hi), 64'hFFFF_FFF9);
        check("reserved_lo", 64'(lo), 64'hCAFE_F00D);

        // Flush in IDLE suppresses a coincident start
        flush = 1'b1;
        issue(3'b000, 32'd3, 32'd4, 0, '0, '0);
        flush = 1'b0;
        check("flush_idle_busy", 64'(busy), 64'd0);

        // MTHI, MULT, flush on RUN cycle 10
        issue(3'b100, 32'h1234_5678, 32'd0, 0, '0, '0);
        check("mthi_hi", 64'(hi), 64'h1234_5678);
        issue(3'b000, 32'd3, 32'd4, 0, '0, '0);
        check("run_busy", 64'(busy), 64'd1);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hi", 64'(hi), 64'h1234_5678);
        check("flush_lo", 64'(lo), 64'hCAFE_F00D);
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("flush_no_done", 64'(ndone), 64'd0);

        // Start during RUN is ignored; back-to-back start in DONE
        issue(3'b001, 32'd6, 32'd7, 1, 32'd0, 32'd42);
        repeat (5) @(negedge clk);
        op = 3'b010; a = 32'd100; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 60 && !done; i++) @(negedge clk);
        check("b2b_done_seen", 64'(done), 64'd1);
        issue(3'b011, 32'd100, 32'd7, 1, 32'd2, 32'd14);
        drain();

        // Reset mid-operation aborts; next start accepted on first edge
        issue(3'b000, 32'd9, 32'd9, 0, '0, '0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_hi", 64'(hi), 64'd0);
        check("midrst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        issue(3'b001, 32'd2, 32'd3, 1, 32'd0, 32'd6);
        drain();
        repeat (5) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_mdu.md
MC_MDU -- requirements
Module: mc_mdu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; SHALL be even and >= 4.
REQ-002 clk  input  1  clock; all state SHALL change on the rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request; sampled on the rising edge of clk.
REQ-005 op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 110/111 reserved.
REQ-006 a  input  WIDTH  operand A (multiplicand, dividend, or MTHI/MTLO data).
REQ-007 b  input  WIDTH  operand B (multiplier or divisor).
REQ-008 flush  input  1  synchronous cancel of an operation in progress.
REQ-009 busy  output  1  high in states RUN and FIX.
REQ-010 done  output  1  one-cycle pulse, high in state DONE.
REQ-011 hi  output  WIDTH  HI register: product upper half, or remainder.
REQ-012 lo  output  WIDTH  LO register: product lower half, or quotient.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, RUN, FIX, DONE.
REQ-014 A start is accepted only in IDLE or DONE; start while busy SHALL be ignored, with no effect on operands or hi/lo.
REQ-015 Accepted MULT/MULTU/DIV/DIVU SHALL latch a, b, op and sign flags, clear the iteration counter, and enter RUN.
REQ-016 Signed ops SHALL iterate on absolute values; unsigned ops SHALL iterate on raw values.
REQ-017 RUN SHALL perform one radix-2 step per cycle (shift-add multiply or restoring divide) for exactly WIDTH cycles, then go to FIX.
REQ-018 FIX SHALL apply sign correction, write hi/lo, and go to DONE after 1 cycle.
REQ-019 DONE SHALL last 1 cycle and then go to IDLE, or to RUN if a new MULT/DIV start is accepted in DONE.
REQ-020 hi/lo SHALL change only on the FIX->DONE edge or on an accepted MTHI/MTLO; results are valid from the cycle done rises.
REQ-021 Latency: with a start sampled at edge N, done SHALL be high in the cycle after edge N+WIDTH+1 (33 cycles for WIDTH=32).
REQ-022 Multiply: {hi,lo} SHALL be the full 2*WIDTH-bit product; signed product is negated when operand signs differ.
REQ-023 Divide: lo SHALL be the quotient, truncated toward zero; hi SHALL be the remainder, with the sign of the dividend.
REQ-024 Divide by zero (b==0, signed or unsigned): hi SHALL be a, unmodified, and lo SHALL be all ones; timing is unchanged.
REQ-025 Signed most-negative / -1: lo SHALL be the most-negative value (wrap) and hi SHALL be 0.
REQ-026 MTHI/MTLO accepted in IDLE or DONE SHALL write a to hi or lo at that edge, stay in or return to IDLE, and not pulse done.
REQ-027 Reserved op codes SHALL be ignored.
REQ-028 flush high in RUN or FIX SHALL return the FSM to IDLE at the next edge, with hi/lo unchanged and no done pulse.
REQ-029 flush SHALL take priority over a coincident start; flush in IDLE or DONE SHALL have no effect except suppressing a coincident start.

Reset
REQ-030 rst low SHALL immediately force: state IDLE, busy=0, done=0, hi=0, lo=0, counter=0, operand registers 0.
REQ-031 rst low mid-operation SHALL abort the operation with no done pulse.
REQ-032 After rst deassert, the first start SHALL be accepted at the first rising edge.

Verification (WIDTH=32)
REQ-033 MULT a=0xFFFFFFFD (-3), b=5 -> done high 33 cycles after start; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-034 MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU a=7, b=0 -> hi=7, lo=0xFFFFFFFF.
REQ-036 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-037 MTHI a=0x12345678, then MULT started, then flush at RUN cycle 10 -> hi stays 0x12345678, busy low next cycle, no done pulse.
REQ-038 Start pulsed during RUN with different operands -> ignored, original result delivered; back-to-back start in DONE -> second result 33 cycles later.
